// File: rtl/ram_b_arbiter.sv
// Two-requester round-robin front end for a single-port synchronous RAM.
// Every access takes four cycles (grant, access, response, ack). All outputs are registered.
module ram_b_arbiter #(
    parameter int unsigned ADDR_W = 20,
    parameter int unsigned DATA_W = 32,
    parameter int unsigned DEPTH  = 128
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  req0,
    input  logic                  we0,
    input  logic [ADDR_W-1:0]     addr0,
    input  logic [DATA_W-1:0]     wdata0,
    output logic                  ack0,
    output logic [DATA_W-1:0]     rdata0,
    output logic                  err0,
    input  logic                  req1,
    input  logic                  we1,
    input  logic [ADDR_W-1:0]     addr1,
    input  logic [DATA_W-1:0]     wdata1,
    output logic                  ack1,
    output logic [DATA_W-1:0]     rdata1,
    output logic                  err1,
    output logic [ADDR_W-1:0]     ram_addr,
    output logic [DATA_W-1:0]     ram_din,
    output logic                  ram_we,
    input  logic [2*DATA_W-17:0]  ram_dout,
    output logic                  busy,
    output logic [1:0]            grant
);

    typedef enum logic [1:0] {IDLE, ACCESS, RESP, DONE} state_e;

    localparam logic [ADDR_W:0] DEPTH_L = (ADDR_W+1)'(DEPTH);

    state_e              state_q, state_d;
    logic                last_grant_q, last_grant_d;   // 1: requester 1 was served last
    logic                we_q, we_d;
    logic                oor_q, oor_d;
    logic                ack0_q, ack0_d, ack1_q, ack1_d;
    logic                err0_q, err0_d, err1_q, err1_d;
    logic [DATA_W-1:0]   rdata0_q, rdata0_d, rdata1_q, rdata1_d;
    logic [ADDR_W-1:0]   ram_addr_q, ram_addr_d;
    logic [DATA_W-1:0]   ram_din_q, ram_din_d;
    logic                ram_we_q, ram_we_d;
    logic [1:0]          grant_q, grant_d;
    logic                busy_q, busy_d;

    logic                pick1;
    logic                sel_we;
    logic [ADDR_W-1:0]   sel_addr;
    logic [DATA_W-1:0]   sel_wdata;
    logic                sel_in_range;
    logic [DATA_W-1:0]   rd_value;

    logic                unused_dout_hi;
    assign unused_dout_hi = ^ram_dout[2*DATA_W-17:DATA_W];

    always_comb begin
        // On a tie the requester that was not served last wins.
        pick1        = req1 && (!req0 || !last_grant_q);
        sel_we       = pick1 ? we1    : we0;
        sel_addr     = pick1 ? addr1  : addr0;
        sel_wdata    = pick1 ? wdata1 : wdata0;
        sel_in_range = {1'b0, sel_addr} < DEPTH_L;
        rd_value     = oor_q ? '0 : ram_dout[DATA_W-1:0];
    end

    always_comb begin
        state_d      = state_q;
        last_grant_d = last_grant_q;
        we_d         = we_q;
        oor_d        = oor_q;
        ack0_d       = ack0_q;
        ack1_d       = ack1_q;
        err0_d       = err0_q;
        err1_d       = err1_q;
        rdata0_d     = rdata0_q;
        rdata1_d     = rdata1_q;
        ram_addr_d   = ram_addr_q;
        ram_din_d    = ram_din_q;
        ram_we_d     = ram_we_q;
        grant_d      = grant_q;

        case (state_q)
            IDLE: begin
                if (req0 || req1) begin
                    ram_addr_d   = sel_addr;
                    ram_din_d    = sel_wdata;
                    ram_we_d     = sel_we && sel_in_range;
                    we_d         = sel_we;
                    oor_d        = !sel_in_range;
                    grant_d      = pick1 ? 2'b10 : 2'b01;
                    last_grant_d = pick1;
                    state_d      = ACCESS;
                end
            end
            ACCESS: begin
                ram_we_d = 1'b0;
                state_d  = RESP;
            end
            RESP: begin
                // Writes leave the read bus undriven, so rdata is only updated on reads.
                if (grant_q[1]) begin
                    if (!we_q) rdata1_d = rd_value;
                    ack1_d = 1'b1;
                    err1_d = oor_q;
                end else begin
                    if (!we_q) rdata0_d = rd_value;
                    ack0_d = 1'b1;
                    err0_d = oor_q;
                end
                state_d = DONE;
            end
            DONE: begin
                ack0_d  = 1'b0;
                ack1_d  = 1'b0;
                err0_d  = 1'b0;
                err1_d  = 1'b0;
                grant_d = 2'b00;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase

        busy_d = (state_d != IDLE);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= IDLE;
            last_grant_q <= 1'b1;
            we_q         <= 1'b0;
            oor_q        <= 1'b0;
            ack0_q       <= 1'b0;
            ack1_q       <= 1'b0;
            err0_q       <= 1'b0;
            err1_q       <= 1'b0;
            rdata0_q     <= '0;
            rdata1_q     <= '0;
            ram_addr_q   <= '0;
            ram_din_q    <= '0;
            ram_we_q     <= 1'b0;
            grant_q      <= 2'b00;
            busy_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            last_grant_q <= last_grant_d;
            we_q         <= we_d;
            oor_q        <= oor_d;
            ack0_q       <= ack0_d;
            ack1_q       <= ack1_d;
            err0_q       <= err0_d;
            err1_q       <= err1_d;
            rdata0_q     <= rdata0_d;
            rdata1_q     <= rdata1_d;
            ram_addr_q   <= ram_addr_d;
            ram_din_q    <= ram_din_d;
            ram_we_q     <= ram_we_d;
            grant_q      <= grant_d;
            busy_q       <= busy_d;
        end
    end

    assign ack0     = ack0_q;
    assign ack1     = ack1_q;
    assign err0     = err0_q;
    assign err1     = err1_q;
    assign rdata0   = rdata0_q;
    assign rdata1   = rdata1_q;
    assign ram_addr = ram_addr_q;
    assign ram_din  = ram_din_q;
    assign ram_we   = ram_we_q;
    assign grant    = grant_q;
    assign busy     = busy_q;

endmodule

// File: tb/tb_ram_b_arbiter.sv
// Bench for ram_b_arbiter: directed scenarios then randomized traffic,
// checked transaction by transaction against a word-level reference model.
module tb_ram_b_arbiter;

    logic        clk = 1'b0;
    logic        rst;
    logic        req0, we0, req1, we1;
    logic [19:0] addr0, addr1;
    logic [31:0] wdata0, wdata1;
    logic        ack0, ack1, err0, err1;
    logic [31:0] rdata0, rdata1;
    logic [19:0] ram_addr;
    logic [31:0] ram_din;
    logic        ram_we;
    logic [47:0] ram_dout;
    logic        busy;
    logic [1:0]  grant;

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    ram_b_arbiter #(.ADDR_W(20), .DATA_W(32), .DEPTH(128)) dut (
        .clk(clk), .rst(rst),
        .req0(req0), .we0(we0), .addr0(addr0), .wdata0(wdata0),
        .ack0(ack0), .rdata0(rdata0), .err0(err0),
        .req1(req1), .we1(we1), .addr1(addr1), .wdata1(wdata1),
        .ack1(ack1), .rdata1(rdata1), .err1(err1),
        .ram_addr(ram_addr), .ram_din(ram_din), .ram_we(ram_we),
        .ram_dout(ram_dout), .busy(busy), .grant(grant)
    );

    // RAM: 1-cycle read latency; on writes the read bus carries a junk pattern standing in for Z.
    logic [31:0] mem [128] = '{default: '0};
    always @(posedge clk) begin
        if (ram_we) begin
            mem[ram_addr[6:0]] <= ram_din;
            ram_dout <= 48'h5A5A_A5A5_C3C3;
        end else begin
            ram_dout <= {16'h0, mem[ram_addr[6:0]]};
        end
    end

    // Reference model state
    logic [31:0] ref_mem [128] = '{default: '0};
    logic [31:0] m_rdata [2];
    int          m_last;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Called at a negedge with request inputs already set; returns at the ack (DONE) negedge.
    task automatic run_txn(input int exp_gap, output int win);
        logic        w_we, inr;
        logic [19:0] w_addr;
        logic [31:0] w_wdata, exp_rd;
        logic [1:0]  exp_grant;
        int          gap;
        if (req0 && req1) win = (m_last == 1) ? 0 : 1;
        else              win = req1 ? 1 : 0;
        w_we      = win ? we1    : we0;
        w_addr    = win ? addr1  : addr0;
        w_wdata   = win ? wdata1 : wdata0;
        inr       = w_addr < 20'd128;
        exp_grant = win ? 2'b10 : 2'b01;
        exp_rd    = w_we ? m_rdata[win] : (inr ? ref_mem[w_addr[6:0]] : 32'h0);

        gap = 0;
        @(negedge clk);
        while (!busy && gap < 8) begin
            check("idle_ack", {ack1, ack0}, 2'b00);
            check("idle_grant", grant, 2'b00);
            gap++;
            @(negedge clk);
        end
        check("grant_gap", gap, exp_gap);
        if (!busy) return;

        check("access_we", ram_we, w_we && inr);
        check("access_addr", ram_addr, w_addr);
        if (w_we && inr) check("access_din", ram_din, w_wdata);
        check("access_grant", grant, exp_grant);
        check("access_ack", {ack1, ack0}, 2'b00);

        @(negedge clk);
        check("resp_we", ram_we, 1'b0);
        check("resp_busy", busy, 1'b1);
        check("resp_ack", {ack1, ack0}, 2'b00);
        check("resp_grant", grant, exp_grant);

        @(negedge clk);
        check("done_ack", {ack1, ack0}, win ? 2'b10 : 2'b01);
        check("done_err", {err1, err0}, win ? {!inr, 1'b0} : {1'b0, !inr});
        check("done_rdata_win", win ? rdata1 : rdata0, exp_rd);
        check("done_rdata_other", win ? rdata0 : rdata1, m_rdata[1-win]);
        check("done_grant", grant, exp_grant);
        check("done_busy", busy, 1'b1);

        if (w_we && inr) ref_mem[w_addr[6:0]] = w_wdata;
        m_rdata[win] = exp_rd;
        m_last = win;
    endtask

    task automatic new_req(input int who);
        logic        r, w;
        logic [19:0] a;
        logic [31:0] d;
        r = ($urandom_range(3) != 0);
        w = 1'($urandom_range(1));
        a = ($urandom_range(4) == 0) ? 20'($urandom_range(20'hFFFFF, 128)) : 20'($urandom_range(127));
        d = $urandom;
        if (who == 0) begin req0 = r; we0 = w; addr0 = a; wdata0 = d; end
        else          begin req1 = r; we1 = w; addr1 = a; wdata1 = d; end
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout: got hang expected finish");
        $fatal(1);
    end

    initial begin
        int win;
        rst = 1'b1;
        req0 = 0; we0 = 0; addr0 = '0; wdata0 = '0;
        req1 = 0; we1 = 0; addr1 = '0; wdata1 = '0;
        m_last = 1; m_rdata[0] = '0; m_rdata[1] = '0;
        repeat (3) @(negedge clk);
        check("rst_outs", {ack0, ack1, err0, err1, ram_we, busy, grant}, '0);
        check("rst_rdata", {rdata0, rdata1}, '0);
        check("rst_ram_bus", {ram_addr, ram_din}, '0);

        // Write then read back through requester 0
        rst = 1'b0;
        req0 = 1; we0 = 1; addr0 = 20'd5; wdata0 = 32'hDEADBEEF;
        run_txn(0, win);
        we0 = 0;
        run_txn(1, win);

        // Out-of-range write and read on requester 1
        req0 = 0;
        req1 = 1; we1 = 1; addr1 = 20'd128; wdata1 = 32'h1234;
        run_txn(1, win);
        we1 = 0; addr1 = 20'd200;
        run_txn(1, win);

        // Write must not disturb rdata0
        req1 = 0;
        req0 = 1; we0 = 1; addr0 = 20'd10; wdata0 = 32'h55AA55AA;
        run_txn(1, win);

        // Reset during ACCESS of a write
        addr0 = 20'd20; wdata0 = 32'hCAFEF00D;
        @(negedge clk);
        check("abort_idle_busy", busy, 1'b0);
        @(negedge clk);
        check("abort_access_we", ram_we, 1'b1);
        #2 rst = 1'b1;
        #1;
        check("abort_we", ram_we, 1'b0);
        check("abort_state", {busy, grant, ack0, ack1}, '0);
        @(negedge clk);
        check("abort_no_ack", {ack0, ack1}, 2'b00);
        rst = 1'b0;
        m_last = 1; m_rdata[0] = '0; m_rdata[1] = '0;

        // Both requesters reading and holding: strict alternation starting with 0
        req0 = 1; we0 = 0; addr0 = 20'd20;
        req1 = 1; we1 = 0; addr1 = 20'd5;
        run_txn(0, win);
        repeat (3) run_txn(1, win);

        // Random traffic; the loser keeps its request pending
        for (int i = 0; i < 60; i++) begin
            new_req(win);
            if (!req0 && !req1) begin
                if (win == 0) req0 = 1; else req1 = 1;
            end
            run_txn(1, win);
        end

        req0 = 0; req1 = 0;
        repeat (3) @(negedge clk);
        check("final_idle", {busy, grant, ack0, ack1}, '0);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
